// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchronizer, debounce filter, and a
// hold/auto-repeat sequencer driving registered level/press/release/repeat outputs.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 8,
  parameter int unsigned REPEAT_CYCLES   = 3
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic dirty_in,
  output logic level_out,
  output logic press_out,
  output logic release_out,
  output logic repeat_out
);

  localparam logic [15:0] DebLast  = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HoldLast = 24'(HOLD_CYCLES - 1);
  localparam logic [23:0] RepLast  = 24'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    UP,
    HOLD,
    REPEAT
  } holdState_e;

  logic        sync1_q;
  logic        sync2_q;
  logic        level_q;
  logic        level_d;
  logic        press_q;
  logic        press_d;
  logic        release_q;
  logic        release_d;
  logic        repeat_q;
  logic [15:0] debCnt_q;
  logic [15:0] debCnt_d;
  logic [23:0] holdCnt_q;
  holdState_e  state_q;

  // A change is accepted on the cycle its deviation has persisted DEBOUNCE_CYCLES times.
  always_comb begin
    debCnt_d  = debCnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      debCnt_d = '0;
    end else if (debCnt_q == DebLast) begin
      debCnt_d  = '0;
      level_d   = ~level_q;
      press_d   = ~level_q;
      release_d = level_q;
    end else begin
      debCnt_d = debCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      debCnt_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= dirty_in;
      sync2_q   <= sync1_q;
      debCnt_q  <= debCnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // The counter reloads on every repeat so REPEAT_CYCLES=1 yields a solid high.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q   <= UP;
      holdCnt_q <= '0;
      repeat_q  <= 1'b0;
    end else begin
      repeat_q <= 1'b0;
      if (release_d) begin
        state_q   <= UP;
        holdCnt_q <= '0;
      end else begin
        case (state_q)
          UP: begin
            holdCnt_q <= '0;
            if (press_d) begin
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (holdCnt_q == HoldLast) begin
              state_q   <= REPEAT;
              holdCnt_q <= '0;
              repeat_q  <= 1'b1;
            end else begin
              holdCnt_q <= holdCnt_q + 24'd1;
            end
          end
          REPEAT: begin
            if (holdCnt_q == RepLast) begin
              holdCnt_q <= '0;
              repeat_q  <= 1'b1;
            end else begin
              holdCnt_q <= holdCnt_q + 24'd1;
            end
          end
          default: begin
            state_q   <= UP;
            holdCnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign level_out   = level_q;
  assign press_out   = press_q;
  assign release_out = release_q;
  assign repeat_out  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: fixed vector table, hand-written corner sequences,
// and a randomized run compared against a delay-line/arithmetic reference model.
module tb_button_conditioner;

  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 3;

  typedef struct {
    logic dirty;
    logic rst;
    logic level;
    logic press;
    logic rel;
    logic rep;
  } vec_t;

  logic clk;
  logic rst_in;
  logic dirty_in;
  logic level;
  logic press;
  logic rel;
  logic rep;
  logic level2;
  logic press2;
  logic rel2;
  logic rep2;

  int checks;
  int errors;

  // Reference model state: the synchronizer is just a two-entry delay line.
  bit syncQ[$];
  bit mLevel;
  bit mPress;
  bit mRel;
  bit mRep;
  int run;
  int edgeNo;
  int pressEdge;

  vec_t tbl[20];
  logic expLevel;
  logic expRep;
  logic expRep2;
  logic expRel;
  logic randVal;
  logic randRst;
  int   randLen;
  int   pc;
  int   rc;
  int   qc;
  int   act;
  int   cyc;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(R)
  ) dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .dirty_in(dirty_in),
    .level_out(level),
    .press_out(press),
    .release_out(rel),
    .repeat_out(rep)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .HOLD_CYCLES(H),
    .REPEAT_CYCLES(1)
  ) dut2 (
    .clk_in(clk),
    .rst_in(rst_in),
    .dirty_in(dirty_in),
    .level_out(level2),
    .press_out(press2),
    .release_out(rel2),
    .repeat_out(rep2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] b);
    vec_t v;
    v.dirty = b[5];
    v.rst   = b[4];
    v.level = b[3];
    v.press = b[2];
    v.rel   = b[1];
    v.rep   = b[0];
    return v;
  endfunction

  task automatic modelEdge(input logic d, input logic r);
    bit s2;
    bit toggled;
    int k;
    mPress = 1'b0;
    mRel   = 1'b0;
    mRep   = 1'b0;
    if (!r) begin
      syncQ  = '{1'b0, 1'b0};
      mLevel = 1'b0;
      run    = 0;
    end else begin
      syncQ.push_back(d);
      s2      = syncQ.pop_front();
      toggled = 1'b0;
      if (s2 != mLevel) begin
        run++;
        if (run == D) begin
          mLevel  = ~mLevel;
          run     = 0;
          toggled = 1'b1;
          if (mLevel) begin
            mPress    = 1'b1;
            pressEdge = edgeNo;
          end else begin
            mRel = 1'b1;
          end
        end
      end else begin
        run = 0;
      end
      // Repeats land at pressEdge + H + k*R while the level stays high.
      if (mLevel && !toggled) begin
        k = edgeNo - pressEdge - H;
        if (k >= 0 && (k % R) == 0) mRep = 1'b1;
      end
    end
    edgeNo++;
  endtask

  task automatic applyStimulus(input logic d, input logic r);
    dirty_in = d;
    rst_in   = r;
    @(posedge clk);
    modelEdge(d, r);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    edgeNo    = 0;
    pressEdge = 0;
    run       = 0;
    dirty_in  = 1'b0;
    rst_in    = 1'b0;

    // Fields: dirty, rst _ level, press, release, repeat. Entry i drives edge E(i-2).
    tbl[0] = mk(6'b00_0000);
    tbl[1] = mk(6'b01_0000);
    for (int i = 2; i <= 6; i++) tbl[i] = mk(6'b11_0000);
    tbl[7] = mk(6'b11_1100);
    for (int i = 8; i <= 19; i++) tbl[i] = mk(6'b11_1000);
    tbl[15] = mk(6'b11_1001);
    tbl[18] = mk(6'b11_1001);

    $display("[TB] clean press from reset");
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].dirty, tbl[i].rst);
      checkOutput($sformatf("tbl%0d level", i), level, tbl[i].level);
      checkOutput($sformatf("tbl%0d press", i), press, tbl[i].press);
      checkOutput($sformatf("tbl%0d release", i), rel, tbl[i].rel);
      checkOutput($sformatf("tbl%0d repeat", i), rep, tbl[i].rep);
    end

    $display("[TB] long hold, repeats, release");
    for (int n = 18; n <= 40; n++) begin
      applyStimulus(n <= 25, 1'b1);
      expLevel = (n <= 30);
      expRep   = (n <= 30) && (((n - 13) % 3) == 0);
      expRep2  = (n <= 30);
      expRel   = (n == 31);
      checkOutput($sformatf("hold E%0d level", n), level, expLevel);
      checkOutput($sformatf("hold E%0d press", n), press, 1'b0);
      checkOutput($sformatf("hold E%0d release", n), rel, expRel);
      checkOutput($sformatf("hold E%0d repeat", n), rep, expRep);
      checkOutput($sformatf("hold E%0d repeat R1", n), rep2, expRep2);
    end

    $display("[TB] short hold");
    pc = 0; rc = 0; qc = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(i < 5, 1'b1);
      pc += int'(press);
      rc += int'(rel);
      qc += int'(rep);
      if (i == 9) checkOutput("short level still high", level, 1'b1);
      if (i == 10) checkOutput("short level fell", level, 1'b0);
    end
    checkCount("short press count", pc, 1);
    checkCount("short release count", rc, 1);
    checkCount("short repeat count", qc, 0);

    $display("[TB] bounce then settle");
    act = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus((i % 4) != 3, 1'b1);
      act += int'(level | press | rel | rep);
    end
    checkCount("bounce activity", act, 0);
    pc = 0;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1);
      pc += int'(press);
    end
    checkCount("settled press count", pc, 1);

    $display("[TB] reset during repeat");
    applyStimulus(1'b1, 1'b0);
    checkOutput("rst level", level, 1'b0);
    checkOutput("rst press", press, 1'b0);
    checkOutput("rst release", rel, 1'b0);
    checkOutput("rst repeat", rep, 1'b0);
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput($sformatf("post-rst F%0d level", j), level, j >= 6);
      checkOutput($sformatf("post-rst F%0d press", j), press, j == 6);
      checkOutput($sformatf("post-rst F%0d release", j), rel, 1'b0);
    end

    $display("[TB] reset during debounce");
    applyStimulus(1'b0, 1'b0);
    act = 0;
    for (int j = 1; j <= 4; j++) begin
      applyStimulus(1'b1, 1'b1);
      act += int'(level | press | rel | rep);
    end
    applyStimulus(1'b1, 1'b0);
    for (int j = 1; j <= 10; j++) begin
      applyStimulus(1'b0, 1'b1);
      act += int'(level | press | rel | rep);
    end
    checkCount("aborted debounce activity", act, 0);

    $display("[TB] randomized run against model");
    cyc = 0;
    while (cyc < 2000) begin
      randVal = 1'($urandom_range(0, 1));
      randLen = int'($urandom_range(1, 24));
      for (int l = 0; l < randLen; l++) begin
        randRst = ($urandom_range(0, 199) != 0);
        applyStimulus(randVal, randRst);
        checkOutput("rand level", level, mLevel);
        checkOutput("rand press", press, mPress);
        checkOutput("rand release", rel, mRel);
        checkOutput("rand repeat", rep, mRep);
        checkOutput("rand R1 level", level2, mLevel);
        checkOutput("rand R1 press", press2, mPress);
        checkOutput("rand R1 release", rel2, mRel);
        checkOutput("rand press/release exclusive", press & rel, 1'b0);
        checkOutput("rand repeat isolation", rep & (press | rel | ~level), 1'b0);
        cyc++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
